// File: rtl/rsp_sender.sv
`default_nettype none
// ============================================================================
// Module   : rsp_sender
// Purpose  : Sends a 4-byte frame (cmd, arg1, arg2, crc) MSB byte first to a
//            byte shifter over a toggle handshake, with optional serial CRC-8.
// Revision : 1.0 - initial release
// ============================================================================
module rsp_sender #(
    parameter bit         CRC_EN   = 1'b1,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] arg1,
    input  logic [7:0] arg2,
    input  logic [7:0] crc_in,
    input  logic       byte_done,
    output logic [7:0] out_byte,
    output logic       byte_load,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] crc_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRC  = 2'd1,
        S_LOAD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [23:0] r_frame,      w_frame_nxt;
    logic [23:0] r_shift,      w_shift_nxt;
    logic [7:0]  r_crc,        w_crc_nxt;
    logic [4:0]  r_bit_cnt,    w_bit_cnt_nxt;
    logic [1:0]  r_idx,        w_idx_nxt;
    logic        r_prev_done,  w_prev_done_nxt;
    logic [7:0]  r_out_byte,   w_out_byte_nxt;
    logic        r_byte_load,  w_byte_load_nxt;
    logic        r_busy,       w_busy_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic [7:0]  r_crc_out,    w_crc_out_nxt;
    logic        w_ack;
    logic        w_fb;

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_nxt      = r_frame;
        w_shift_nxt      = r_shift;
        w_crc_nxt        = r_crc;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_idx_nxt        = r_idx;
        w_prev_done_nxt  = r_prev_done;
        w_out_byte_nxt   = r_out_byte;
        w_byte_load_nxt  = r_byte_load;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_crc_out_nxt    = r_crc_out;
        w_ack            = byte_done ^ r_prev_done;
        w_fb             = r_crc[7] ^ r_shift[23];

        case (r_state)
            S_IDLE: begin
                // A stray toggle seen while idle is absorbed so it cannot ack a later byte.
                if (w_ack) begin
                    w_prev_done_nxt = byte_done;
                end
                if (start) begin
                    w_frame_nxt   = {cmd, arg1, arg2};
                    w_shift_nxt   = {cmd, arg1, arg2};
                    w_crc_nxt     = CRC_INIT;
                    w_bit_cnt_nxt = 5'd0;
                    w_idx_nxt     = 2'd0;
                    w_busy_nxt    = 1'b1;
                    if (CRC_EN) begin
                        w_state_nxt = S_CRC;
                    end else begin
                        w_crc_out_nxt = crc_in;
                        w_state_nxt   = S_LOAD;
                    end
                end
            end
            S_CRC: begin
                w_crc_nxt     = {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
                w_shift_nxt   = {r_shift[22:0], 1'b0};
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd23) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (CRC_EN) begin
                    w_crc_out_nxt = r_crc;
                end
                w_out_byte_nxt  = r_frame[23:16];
                w_byte_load_nxt = ~r_byte_load;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (w_ack) begin
                    w_prev_done_nxt = byte_done;
                    w_idx_nxt       = r_idx + 2'd1;
                    case (r_idx)
                        2'd0: begin
                            w_out_byte_nxt  = r_frame[15:8];
                            w_byte_load_nxt = ~r_byte_load;
                        end
                        2'd1: begin
                            w_out_byte_nxt  = r_frame[7:0];
                            w_byte_load_nxt = ~r_byte_load;
                        end
                        2'd2: begin
                            w_out_byte_nxt  = r_crc_out;
                            w_byte_load_nxt = ~r_byte_load;
                        end
                        default: begin
                            w_busy_nxt       = 1'b0;
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = S_IDLE;
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_frame      <= 24'd0;
            r_shift      <= 24'd0;
            r_crc        <= 8'd0;
            r_bit_cnt    <= 5'd0;
            r_idx        <= 2'd0;
            r_prev_done  <= 1'b0;
            r_out_byte   <= 8'd0;
            r_byte_load  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_out    <= 8'd0;
        end else if (en) begin
            r_state      <= w_state_nxt;
            r_frame      <= w_frame_nxt;
            r_shift      <= w_shift_nxt;
            r_crc        <= w_crc_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_prev_done  <= w_prev_done_nxt;
            r_out_byte   <= w_out_byte_nxt;
            r_byte_load  <= w_byte_load_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_crc_out    <= w_crc_out_nxt;
        end
    end

    assign out_byte   = r_out_byte;
    assign byte_load  = r_byte_load;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign crc_out    = r_crc_out;

endmodule
`default_nettype wire

// File: tb/tb_rsp_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsp_sender
// Purpose  : Drives a CRC-generating and a pass-through rsp_sender side by side
//            against a shifter model and a CRC-8 long-division reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rsp_sender;

    localparam int MAX_CYC = 400;

    logic       clk = 1'b0;
    logic       reset_n, en, start;
    logic [7:0] cmd, arg1, arg2, crc_in;
    logic [1:0] byte_done, byte_load, busy, frame_done;
    logic [7:0] out_byte [2];
    logic [7:0] crc_out  [2];

    int checks   = 0;
    int failures = 0;

    // Shifter / scoreboard state; index 0 = CRC generating, 1 = pass-through.
    logic [1:0] seen_load;
    int         ack_cnt     [2];
    int         ngot        [2];
    int         fd_cnt      [2];
    int         first_lat   [2];
    int         total_loads [2];
    bit         done_seen   [2];
    logic [7:0] got         [2][4];
    logic [7:0] exp_bytes   [2][4];
    int         en_edges;

    always #5 clk = ~clk;

    rsp_sender #(.CRC_EN(1'b1), .CRC_POLY(8'h07), .CRC_INIT(8'h00)) u_dut_crc (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start),
        .cmd(cmd), .arg1(arg1), .arg2(arg2), .crc_in(crc_in),
        .byte_done(byte_done[0]), .out_byte(out_byte[0]), .byte_load(byte_load[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .crc_out(crc_out[0])
    );

    rsp_sender #(.CRC_EN(1'b0), .CRC_POLY(8'h07), .CRC_INIT(8'h00)) u_dut_raw (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start),
        .cmd(cmd), .arg1(arg1), .arg2(arg2), .crc_in(crc_in),
        .byte_done(byte_done[1]), .out_byte(out_byte[1]), .byte_load(byte_load[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .crc_out(crc_out[1])
    );

    // Remainder of (message * x^8) divided by x^8 + poly.
    function automatic logic [7:0] crc8(input logic [23:0] m);
        logic [31:0] r;
        r = {m, 8'h00};
        for (int i = 31; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        logic en_at_edge;
        int   idx;
        en_at_edge = en;
        @(posedge clk);
        #1;
        if (en_at_edge) en_edges++;
        for (int k = 0; k < 2; k++) begin
            if (frame_done[k]) begin
                fd_cnt[k]++;
                done_seen[k] = 1'b1;
            end
            if (byte_load[k] !== seen_load[k]) begin
                seen_load[k] = byte_load[k];
                idx = (ngot[k] < 4) ? ngot[k] : 3;
                got[k][idx] = out_byte[k];
                if (ngot[k] == 0) first_lat[k] = en_edges;
                ngot[k]++;
                total_loads[k]++;
                ack_cnt[k] = $urandom_range(1, 4);
            end else if (ack_cnt[k] > 0) begin
                idx = (ngot[k] < 4) ? ngot[k] - 1 : 3;
                chk("hold", k, 32'(out_byte[k]), 32'(exp_bytes[k][idx]));
                ack_cnt[k]--;
                if (ack_cnt[k] == 0) byte_done[k] = ~byte_done[k];
            end
        end
    endtask

    task automatic chk_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_byte",   k, 32'(out_byte[k]),   32'd0);
            chk("rst_byte_load",  k, 32'(byte_load[k]),  32'd0);
            chk("rst_busy",       k, 32'(busy[k]),       32'd0);
            chk("rst_frame_done", k, 32'(frame_done[k]), 32'd0);
            chk("rst_crc_out",    k, 32'(crc_out[k]),    32'd0);
        end
    endtask

    task automatic begin_frame(input logic [7:0] c, a1, a2, ci);
        exp_bytes[0][0] = c;  exp_bytes[0][1] = a1; exp_bytes[0][2] = a2; exp_bytes[0][3] = crc8({c, a1, a2});
        exp_bytes[1][0] = c;  exp_bytes[1][1] = a1; exp_bytes[1][2] = a2; exp_bytes[1][3] = ci;
        for (int k = 0; k < 2; k++) begin
            ngot[k] = 0; fd_cnt[k] = 0; done_seen[k] = 1'b0; first_lat[k] = -1;
            for (int j = 0; j < 4; j++) got[k][j] = 'x;
        end
        cmd = c; arg1 = a1; arg2 = a2; crc_in = ci; en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        en_edges = 0;
        for (int k = 0; k < 2; k++) begin
            chk("busy_on",   k, 32'(busy[k]),       32'd1);
            chk("fd_low",    k, 32'(frame_done[k]), 32'd0);
        end
        // Frame must be snapshotted; scramble the inputs behind it.
        cmd = 8'($urandom); arg1 = 8'($urandom); arg2 = 8'($urandom); crc_in = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] c, a1, a2, ci, input int drop_at, input bit spam);
        int n;
        begin_frame(c, a1, a2, ci);
        n = 0;
        while (!(done_seen[0] && done_seen[1]) && n < MAX_CYC) begin
            if (n == drop_at)      en = 1'b0;
            if (n == drop_at + 10) en = 1'b1;
            start = spam && busy[0] && busy[1] && ($urandom_range(0, 2) == 0);
            step();
            n++;
        end
        start = 1'b0;
        en    = 1'b1;
        chk("frame_timeout", 0, 32'(n < MAX_CYC), 32'd1);
        for (int k = 0; k < 2; k++) begin
            chk("nbytes", k, 32'(ngot[k]), 32'd4);
            for (int j = 0; j < 4; j++) chk("byte", k, 32'(got[k][j]), 32'(exp_bytes[k][j]));
            chk("crc_out",    k, 32'(crc_out[k]), 32'(exp_bytes[k][3]));
            chk("first_lat",  k, 32'(first_lat[k]), (k == 0) ? 32'd25 : 32'd1);
            chk("fd_count",   k, 32'(fd_cnt[k]), 32'd1);
            chk("busy_off",   k, 32'(busy[k]), 32'd0);
        end
    endtask

    task automatic stray_idle_toggle();
        byte_done = ~byte_done;
        step(); step(); step();
        for (int k = 0; k < 2; k++) begin
            chk("stray_out_byte",  k, 32'(out_byte[k]),  32'(exp_bytes[k][3]));
            chk("stray_byte_load", k, 32'(byte_load[k]), 32'(total_loads[k] % 2));
            chk("stray_busy",      k, 32'(busy[k]),      32'd0);
        end
    endtask

    task automatic reset_mid_wait(input logic [7:0] c, a1, a2, ci);
        int n;
        begin_frame(c, a1, a2, ci);
        n = 0;
        while (ngot[0] < 2 && n < MAX_CYC) begin
            step();
            n++;
        end
        chk("mid_timeout", 0, 32'(n < MAX_CYC), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        byte_done = 2'b00;
        seen_load = 2'b00;
        for (int k = 0; k < 2; k++) begin
            ack_cnt[k] = 0;
            total_loads[k] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; start = 1'b0;
        cmd = 8'd0; arg1 = 8'd0; arg2 = 8'd0; crc_in = 8'd0;
        byte_done = 2'b00; seen_load = 2'b00; en_edges = 0;
        for (int k = 0; k < 2; k++) begin
            ack_cnt[k] = 0; ngot[k] = 0; fd_cnt[k] = 0; first_lat[k] = -1;
            total_loads[k] = 0; done_seen[k] = 1'b0;
            for (int j = 0; j < 4; j++) exp_bytes[k][j] = 8'd0;
        end
        #12;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        en = 1'b1;

        run_frame(8'h00, 8'h00, 8'h01, 8'($urandom), -1, 1'b0);
        chk("crc_vec_07", 0, 32'(crc_out[0]), 32'h07);
        run_frame(8'h00, 8'h00, 8'h00, 8'($urandom), -1, 1'b0);
        chk("crc_vec_00", 0, 32'(crc_out[0]), 32'h00);
        run_frame(8'h00, 8'h00, 8'h02, 8'($urandom), -1, 1'b0);
        chk("crc_vec_0E", 0, 32'(crc_out[0]), 32'h0E);
        run_frame(8'hA5, 8'h3C, 8'h81, 8'h5A, -1, 1'b1);
        chk("raw_crc_5A", 1, 32'(crc_out[1]), 32'h5A);

        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 5, 1'b0);
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 30, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b1);
        end

        stray_idle_toggle();
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);

        reset_mid_wait(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
